// File: rtl/gradient_flow_sequencer_if.sv
// Host command / pump-valve driver bundle for the gradient flow sequencer.
interface gradient_flow_sequencer_if #(
  parameter int unsigned N_OUT = 9
);
  logic             start;
  logic             abort;
  logic [7:0]       ratio;
  logic [1:0]       pump_en;
  logic [1:0]       pump_step;
  logic [N_OUT-1:0] valve_sel;
  logic [3:0]       outlet_idx;
  logic             sample_strobe;
  logic             busy;
  logic             done;

  // Host side: issues commands, observes pump/valve activity.
  modport master (
    output start, abort, ratio,
    input  pump_en, pump_step, valve_sel, outlet_idx, sample_strobe, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, abort, ratio,
    output pump_en, pump_step, valve_sel, outlet_idx, sample_strobe, busy, done
  );
endinterface

// File: rtl/gradient_flow_sequencer.sv
// Runs one gradient experiment: prime pumps, settle, then scan outlet valves.
module gradient_flow_sequencer #(
  parameter int unsigned N_OUT         = 9,
  parameter int unsigned STEP_DIV      = 16,
  parameter int unsigned PRIME_STEPS   = 64,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned DWELL_CYCLES  = 128,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  gradient_flow_sequencer_if.slave bus
);

  localparam int unsigned IDX_W   = 4;
  localparam int unsigned RATIO_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_SETTLE,
    ST_COLLECT,
    ST_DONE
  } state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   div_q, div_nxt;
  logic [CNT_W-1:0]   phase_q, phase_nxt;
  logic [IDX_W-1:0]   idx_q, idx_nxt;
  logic [RATIO_W-1:0] acc_q, acc_nxt;
  logic [RATIO_W-1:0] ratio_q, ratio_nxt;

  logic               a_step;
  logic               prime_last;
  logic               settle_last;
  logic               dwell_last;
  logic               idx_last;

  logic               busy_d, done_d, sample_d;
  logic [1:0]         pump_en_d, pump_step_d;
  logic [N_OUT-1:0]   valve_d;
  logic [IDX_W-1:0]   idx_d;

  logic               busy_q, done_q, sample_q;
  logic [1:0]         pump_en_q, pump_step_q;
  logic [N_OUT-1:0]   valve_q;
  logic [IDX_W-1:0]   idx_out_q;

  // Terminal-count decodes for the current cycle.
  always_comb begin
    a_step      = (div_q == CNT_W'(STEP_DIV - 1));
    prime_last  = (phase_q == CNT_W'(PRIME_STEPS - 1));
    settle_last = (phase_q == CNT_W'(SETTLE_CYCLES - 1));
    dwell_last  = (phase_q == CNT_W'(DWELL_CYCLES - 1));
    idx_last    = (idx_q == IDX_W'(N_OUT - 1));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // FSM next-state logic; abort wins over phase completion in busy states.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:    if (bus.start) state_nxt = ST_PRIME;
      ST_PRIME: begin
        if (bus.abort)                   state_nxt = ST_IDLE;
        else if (a_step && prime_last)   state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (bus.abort)                   state_nxt = ST_IDLE;
        else if (settle_last)            state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (bus.abort)                   state_nxt = ST_IDLE;
        else if (dwell_last && idx_last) state_nxt = ST_DONE;
      end
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Counter next values; everything clears whenever the run is not continuing.
  always_comb begin
    div_nxt   = '0;
    phase_nxt = '0;
    idx_nxt   = '0;
    acc_nxt   = '0;
    ratio_nxt = ratio_q;
    if (state_q == ST_IDLE) begin
      if (bus.start) ratio_nxt = bus.ratio;
    end else if (state_nxt inside {ST_PRIME, ST_SETTLE, ST_COLLECT}) begin
      div_nxt = a_step ? '0 : div_q + CNT_W'(1);
      acc_nxt = a_step ? acc_q + ratio_q : acc_q;
      case (state_q)
        ST_PRIME: begin
          if (a_step) phase_nxt = prime_last ? '0 : phase_q + CNT_W'(1);
          else        phase_nxt = phase_q;
        end
        ST_SETTLE:  phase_nxt = settle_last ? '0 : phase_q + CNT_W'(1);
        ST_COLLECT: begin
          phase_nxt = dwell_last ? '0 : phase_q + CNT_W'(1);
          idx_nxt   = dwell_last ? idx_q + IDX_W'(1) : idx_q;
        end
        default: phase_nxt = '0;
      endcase
    end
  end

  // Output decode from next-cycle values so registered outputs align with state.
  always_comb begin
    busy_d      = (state_nxt inside {ST_PRIME, ST_SETTLE, ST_COLLECT});
    done_d      = (state_nxt == ST_DONE);
    pump_en_d   = busy_d ? 2'b11 : 2'b00;
    pump_step_d = 2'b00;
    valve_d     = '0;
    idx_d       = '0;
    sample_d    = 1'b0;
    if (busy_d && (div_nxt == CNT_W'(STEP_DIV - 1))) begin
      pump_step_d[0] = 1'b1;
      pump_step_d[1] = ((9'(acc_nxt) + 9'(ratio_nxt)) > 9'd255);
    end
    if (state_nxt == ST_COLLECT) begin
      valve_d  = N_OUT'(1) << idx_nxt;
      idx_d    = idx_nxt;
      sample_d = (phase_nxt == CNT_W'(DWELL_CYCLES - 1));
    end
  end

  // Datapath counters and latched ratio.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      phase_q <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      ratio_q <= '0;
    end else begin
      div_q   <= div_nxt;
      phase_q <= phase_nxt;
      idx_q   <= idx_nxt;
      acc_q   <= acc_nxt;
      ratio_q <= ratio_nxt;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sample_q    <= 1'b0;
      pump_en_q   <= 2'b00;
      pump_step_q <= 2'b00;
      valve_q     <= '0;
      idx_out_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      sample_q    <= sample_d;
      pump_en_q   <= pump_en_d;
      pump_step_q <= pump_step_d;
      valve_q     <= valve_d;
      idx_out_q   <= idx_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.sample_strobe = sample_q;
  assign bus.pump_en       = pump_en_q;
  assign bus.pump_step     = pump_step_q;
  assign bus.valve_sel     = valve_q;
  assign bus.outlet_idx    = idx_out_q;

endmodule

// File: doc/gradient_flow_sequencer.md
# gradient_flow_sequencer

Digital controller that runs one gradient-generation experiment on the two-inlet, nine-outlet serpentine gradient network. It drives the two inlet syringe pumps with step pulses at a programmable flow ratio and primes the network. It waits for the gradient to settle, then opens the outlet collection valves one at a time for a fixed dwell. It sits between the host command interface and the pump/valve driver pins of the chip.

## Interface
- N_OUT, 9: number of outlet valves (last stage of the network).
- STEP_DIV, 16: clock cycles per pump-A step period; must be ≥ 2.
- PRIME_STEPS, 64: pump-A steps in the prime phase; must be ≥ 1.
- SETTLE_CYCLES, 256: settle duration in cycles; must be ≥ 1.
- DWELL_CYCLES, 128: collection time per outlet in cycles; must be ≥ 1.
- CNT_W, 16: width of the internal phase counters; must hold every count above.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level, sampled only in IDLE; begins a run.
- abort  in  1  level, sampled in every non-IDLE state; ends the run immediately.
- ratio  in  8  pump-B rate relative to pump A, expressed as ratio/256; latched when start is accepted.
- pump_en  out  2  bit0 enables pump A, bit1 enables pump B.
- pump_step  out  2  one-cycle step pulses; bit0 is pump A, bit1 is pump B.
- valve_sel  out  N_OUT  one-hot outlet valve open mask.
- outlet_idx  out  4  index of the outlet currently being collected.
- sample_strobe  out  1  one-cycle pulse on the last dwell cycle of each outlet.
- busy  out  1  high in PRIME, SETTLE and COLLECT.
- done  out  1  one-cycle pulse when a run completes normally.

## Operation
- States and transitions:
  - IDLE → PRIME on start.
  - PRIME → SETTLE after PRIME_STEPS pump-A steps.
  - SETTLE → COLLECT after SETTLE_CYCLES cycles.
  - COLLECT → DONE after the last outlet's dwell.
  - DONE → IDLE unconditionally after one cycle.
- Abort: in PRIME, SETTLE or COLLECT, abort sends the FSM to IDLE on the next edge. No done pulse is generated, and all outputs are 0 from that edge. Abort in DONE is ignored.
- Start while not in IDLE is ignored; start is not queued.
- Pump stepping:
  - On PRIME entry, the divider counter and the 8-bit ratio accumulator are cleared.
  - The divider runs 0..STEP_DIV-1 continuously through PRIME, SETTLE and COLLECT.
  - pump_step[0] pulses when the divider equals STEP_DIV-1.
  - On every A step, the accumulator becomes acc + ratio (9-bit sum). The low 8 bits are kept.
  - pump_step[1] pulses in the same cycle as the A step whenever the sum carries out of bit 7.
  - ratio=0: pump B never steps. ratio=128: B steps on every second A step. ratio=255: B steps on 255 of every 256 A steps.
- pump_en is 2'b11 in PRIME, SETTLE and COLLECT, and 0 otherwise. pump_en[1] stays high even when ratio=0.
- Collection:
  - outlet_idx starts at 0 on COLLECT entry.
  - valve_sel = 1 << outlet_idx, held for DWELL_CYCLES cycles.
  - sample_strobe pulses on the last of those cycles. outlet_idx then increments, with no gap cycle.
  - After outlet N_OUT-1 the FSM moves to DONE.
  - valve_sel is 0 outside COLLECT. outlet_idx reads 0 outside COLLECT.
- DONE: pumps off, valves closed, done=1, busy=0.

## Timing
- Reset: every output is 0, the FSM is in IDLE, and all counters and the accumulator are 0. Reset asserted mid-run forces this state asynchronously.
- All outputs are registered.
- Start sampled high at edge 0 gives busy=1 and pump_en=2'b11 from edge 1 (PRIME entry).
- First pump_step[0] occurs STEP_DIV cycles after PRIME entry.
- Phase durations in cycles:
  - PRIME: PRIME_STEPS × STEP_DIV.
  - SETTLE: SETTLE_CYCLES.
  - COLLECT: N_OUT × DWELL_CYCLES.
  - DONE: 1.
- The step pulse on the last PRIME cycle is emitted in that cycle.
- Abort and start high in the same IDLE cycle: start is accepted; abort is only looked at from PRIME on.

## Test plan
- Full run with STEP_DIV=4, PRIME_STEPS=3, SETTLE_CYCLES=5, DWELL_CYCLES=2, ratio=128: start pulsed at cycle 0. Required response:
  - busy is high for exactly 35 cycles (cycles 1–35).
  - done pulses at cycle 36.
  - 8 A steps occur before COLLECT ends.
  - B steps on every 2nd A step.
- Outlet scan, same parameters: valve_sel steps through 9'h001, 9'h002, … 9'h100, two cycles each. sample_strobe is seen 9 times, on the 2nd cycle of each outlet.
- Ratio extremes: ratio=0 gives no pump_step[1] pulse in the whole run. ratio=255 over 256 A steps (PRIME_STEPS=256) gives exactly 255 B pulses.
- Abort in the 3rd SETTLE cycle: next cycle busy=0, pump_en=0 and valve_sel=0, with no done pulse. A new start then runs to normal completion.
- Start held high for the whole run: after DONE the FSM re-enters PRIME one cycle later. start pulses during busy have no effect on phase lengths.
- rst_n deasserted for one cycle mid-COLLECT: all outputs are 0 immediately (asynchronously). The block stays IDLE until the next start.
